// File: rtl/io_manager_mm.sv
// Memory-mapped I/O manager. The 16 addresses at the top of the CPU
// address space hold output registers and debounced input ports with
// sticky edge capture and a maskable interrupt. Every other address is
// passed through to the external SRAM.
module io_manager_mm #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int SRAM_AW = 18,
    parameter int N_OUT   = 2,
    parameter int OUT_W   = 10,
    parameter int N_IN    = 1,
    parameter int IN_W    = 4,
    parameter int DB_DIV  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        dir_in,
    input  logic                     oe,
    input  logic [N_IN*IN_W-1:0]     buttons,
    inout  wire  [DATA_W-1:0]        Datos,
    output logic [4:0]               sram_control,
    output logic [SRAM_AW-1:0]       dir_out,
    output logic [N_OUT*OUT_W-1:0]   out_ports,
    output logic                     irq
);

    localparam int NB       = N_IN * IN_W;
    localparam int PS_W     = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam int OFF_LIVE = N_OUT;
    localparam int OFF_EDGE = N_OUT + N_IN;
    localparam int OFF_MASK = N_OUT + 2 * N_IN;

    logic              w_io_sel;
    logic [3:0]        w_off;
    logic              w_wr;
    logic              w_tick;
    logic [DATA_W-1:0] w_rdata;
    logic [NB-1:0]     w_deb;
    logic [NB-1:0]     w_edge;
    logic [NB-1:0]     w_mask;
    logic              w_unused_bits;

    logic [PS_W-1:0]   r_presc;
    logic [1:0]        r_sync_ok;
    logic              r_samp_ok;
    logic              r_irq;

    // The top 16 addresses are reversed so that the highest address is offset 0.
    assign w_io_sel      = &dir_in[ADDR_W-1:4];
    assign w_off         = ~dir_in[3:0];
    assign w_wr          = w_io_sel & oe;
    assign w_tick        = (r_presc == '0);
    assign dir_out       = SRAM_AW'(dir_in);
    assign irq           = r_irq;
    assign w_unused_bits = ^Datos;

    // Shared debounce prescaler, wrapping at DB_DIV-1.
    always_ff @(posedge clk) begin
        if (reset)
            r_presc <= '0;
        else if (r_presc == PS_W'(DB_DIV - 1))
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Tracks when the synchroniser and the debounce sampler hold real input
    // rather than reset values, so edge arming only looks at genuine data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_ok <= '0;
            r_samp_ok <= 1'b0;
        end else begin
            r_sync_ok <= {r_sync_ok[0], 1'b1};
            if (w_tick && r_sync_ok[1])
                r_samp_ok <= 1'b1;
        end
    end

    genvar gi;

    // Output registers, one writable offset each.
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
        logic [OUT_W-1:0] r_out;

        // Load from the data bus on a CPU write to this register's offset.
        always_ff @(posedge clk) begin
            if (reset)
                r_out <= '0;
            else if (w_wr && w_off == 4'(gi))
                r_out <= Datos[OUT_W-1:0];
        end

        assign out_ports[gi*OUT_W +: OUT_W] = r_out;
    end

    // Input ports: synchroniser, debouncer, sticky edge capture and irq mask.
    for (gi = 0; gi < N_IN; gi++) begin : g_in
        logic [IN_W-1:0] r_sync1, r_sync2, r_samp, r_deb, r_deb_d, r_arm;
        logic [IN_W-1:0] r_edge, r_mask;
        logic [IN_W-1:0] w_stable, w_set, w_clr;

        assign w_stable = ~(r_samp ^ r_sync2);
        // An edge only counts once the bit has been seen debounced low
        // after reset; inputs already high at reset release stay silent.
        assign w_set    = r_deb & ~r_deb_d & r_arm;
        assign w_clr    = (w_wr && w_off == 4'(OFF_EDGE + gi)) ? Datos[IN_W-1:0] : '0;

        // Synchronise, then accept a new level only when two ticks agree.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= '0;
                r_sync2 <= '0;
                r_samp  <= '0;
                r_deb   <= '0;
                r_deb_d <= '0;
                r_arm   <= '0;
            end else begin
                r_sync1 <= buttons[gi*IN_W +: IN_W];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (w_tick) begin
                    r_samp <= r_sync2;
                    r_deb  <= (w_stable & r_sync2) | (~w_stable & r_deb);
                    if (r_samp_ok)
                        r_arm <= r_arm | (w_stable & ~r_sync2);
                end
            end
        end

        // Sticky edge bits (set beats write-one-to-clear) and the irq mask.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_edge <= '0;
                r_mask <= '0;
            end else begin
                r_edge <= (r_edge & ~w_clr) | w_set;
                if (w_wr && w_off == 4'(OFF_MASK + gi))
                    r_mask <= Datos[IN_W-1:0];
            end
        end

        assign w_deb[gi*IN_W +: IN_W]  = r_deb;
        assign w_edge[gi*IN_W +: IN_W] = r_edge;
        assign w_mask[gi*IN_W +: IN_W] = r_mask;
    end

    // Registered interrupt: any captured edge that is enabled.
    always_ff @(posedge clk) begin
        if (reset)
            r_irq <= 1'b0;
        else
            r_irq <= |(w_edge & w_mask);
    end

    // Read mux; unmapped offsets read zero.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < N_OUT; k++)
            if (w_off == 4'(k))
                w_rdata[OUT_W-1:0] = out_ports[k*OUT_W +: OUT_W];
        for (int j = 0; j < N_IN; j++) begin
            if (w_off == 4'(OFF_LIVE + j))
                w_rdata[IN_W-1:0] = w_deb[j*IN_W +: IN_W];
            if (w_off == 4'(OFF_EDGE + j))
                w_rdata[IN_W-1:0] = w_edge[j*IN_W +: IN_W];
            if (w_off == 4'(OFF_MASK + j))
                w_rdata[IN_W-1:0] = w_mask[j*IN_W +: IN_W];
        end
    end

    // SRAM control word: writes share one encoding, reads differ by target.
    always_comb begin
        sram_control = 5'b00100;
        if (oe)
            sram_control = 5'b01000;
        else if (w_io_sel)
            sram_control = 5'b11111;
    end

    assign Datos = (w_io_sel && !oe) ? w_rdata : 'z;

endmodule

// File: doc/io_manager_mm.md
# io_manager_mm

Parametrised memory-mapped I/O manager for the basic CPU. It decodes a 16-entry window at the top of the CPU address space and places there N_OUT writable output registers and N_IN input ports. Each input port is synchronised and debounced, with sticky rising-edge capture and a maskable interrupt. All other addresses pass through to the external SRAM with the usual control encoding.

## Interface
- ADDR_W, 16, CPU address width.
- DATA_W, 16, CPU data bus width.
- SRAM_AW, 18, SRAM address width; must be ≥ ADDR_W.
- N_OUT, 2, number of output registers.
- OUT_W, 10, width of each output register; must be ≤ DATA_W.
- N_IN, 1, number of input ports.
- IN_W, 4, width of each input port; must be ≤ DATA_W.
- DB_DIV, 1, debounce sample period in clk cycles; must be ≥ 1.
- Legal configuration: N_OUT + 3·N_IN ≤ 16.
- clk, input, 1, single system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- dir_in, input, ADDR_W, CPU address.
- oe, input, 1, 1 = CPU write cycle, 0 = CPU read cycle.
- buttons, input, N_IN·IN_W, asynchronous inputs; port j occupies bits [j·IN_W +: IN_W].
- Datos, inout, DATA_W, bidirectional CPU/SRAM data bus.
- sram_control, output, 5, SRAM control word.
- dir_out, output, SRAM_AW, SRAM address; equals zero-extended dir_in.
- out_ports, output, N_OUT·OUT_W, output register k at bits [k·OUT_W +: OUT_W].
- irq, output, 1, registered interrupt request.

## Operation
- **Window select:** io_sel = (dir_in[ADDR_W-1:4] all ones). Offset off = ~dir_in[3:0], so 0xFFFF maps to off 0.
- **Offset map:**
  - Offsets 0..N_OUT-1: output register k (read/write).
  - Offsets N_OUT+j: live debounced value of port j (read-only).
  - Offsets N_OUT+N_IN+j: sticky edge register of port j (read; write-one-to-clear).
  - Offsets N_OUT+2·N_IN+j: irq enable mask of port j (read/write).
  - Remaining offsets read 0; writes to them are ignored.
- **Reads:**
  - Read data is zero-extended to DATA_W and selected combinationally.
  - Datos is driven only when io_sel && !oe. Otherwise Datos is high-Z.
- **sram_control:**
  - io_sel: 5'b01000 when oe=1, 5'b11111 when oe=0.
  - Not io_sel: 5'b01000 when oe=1, 5'b00100 when oe=0.
- **Writes:** a write is performed on a clk edge with io_sel && oe. The target register loads Datos[width-1:0]. A write held for several cycles rewrites the same value each cycle.
- **Input path (per bit):**
  - Two-flop synchroniser: sync1, sync2.
  - A shared prescaler counts 0..DB_DIV-1 and asserts tick when the count is 0.
  - On each tick: samp <= sync2, and if samp == sync2 then deb <= sync2.
  - deb_d <= deb every cycle.
  - Edge bit sets when deb & ~deb_d.
  - Edge bit clears on a write-one to its edge register.
  - A set and a clear on the same cycle: set wins.
- **Interrupt:** irq <= |(edge & mask) across all ports, updated every cycle.
- **Reset:** sets to 0 all output registers, sync1, sync2, samp, deb, deb_d, edge, mask, the prescaler, and irq. out_ports therefore reads 0 while reset is asserted.

## Timing
- **Output registers:** a write on edge n appears on out_ports after edge n. A read in the following cycle returns the new value.
- **Input latency (DB_DIV=1):** a button change settled before edge 1 gives:
  - sync2 after edge 2,
  - deb after edge 4,
  - edge bit after edge 5,
  - irq after edge 6, if masked in.
- **Input latency (DB_DIV=D):** deb updates on the second tick after the change reaches sync2.
- **Glitch rejection:** a pulse shorter than one tick period never reaches deb.
- **Reset mid-operation:** any pending debounce, edge or irq state is discarded. No edge is reported for inputs that are already high when reset releases, until they go low and then high again.
- **Combinational paths:** sram_control, dir_out and read data are combinational from dir_in and oe. No cycle latency is added.

## Test plan
- **Reset:** assert reset 3 cycles with buttons=4'hF → out_ports=0, irq=0. After release, reading 0xFFFD returns 0x000F only from edge 4 onward; 0xFFFC stays 0.
- **Write/readback:** write 0x03A5 to 0xFFFF, then 0x00C3 to 0xFFFE → out_ports = {10'h0C3, 10'h3A5}. Read of 0xFFFF returns 0x03A5 with sram_control=11111.
- **Edge capture and irq:** write 0x0004 to 0xFFFB; raise buttons[2] → 0xFFFC reads 0x0004 after edge 5; irq=1 after edge 6. Write 0x0004 to 0xFFFC → irq=0 on the next cycle.
- **Set/clear collision:** a W1C write to 0xFFFC on the same edge that a new edge is detected → the edge bit stays 1.
- **Debounce (DB_DIV=4):** a 3-cycle pulse on buttons[0] → deb and edge unchanged. A 12-cycle pulse → edge[0]=1.
- **Pass-through:** dir_in=0x1234 with oe=0 → sram_control=00100, dir_out=18'h01234, Datos undriven. Write to unmapped offset 0xFFF0 → no register changes.
